// File: rtl/serv_bus_arbiter_if.sv
// Bus bundle between the core's ibus/dbus, the arbiter and the shared Wishbone port.
// The arbiter uses the slave view; the core/memory side uses the master view.
interface serv_bus_arbiter_if;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic        ibus_err;

  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic        dbus_err;

  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;

  modport slave (
    input  ibus_adr, ibus_cyc,
    input  dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    input  wb_rdt, wb_ack,
    output ibus_rdt, ibus_ack, ibus_err,
    output dbus_rdt, dbus_ack, dbus_err,
    output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc
  );

  modport master (
    output ibus_adr, ibus_cyc,
    output dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    output wb_rdt, wb_ack,
    input  ibus_rdt, ibus_ack, ibus_err,
    input  dbus_rdt, dbus_ack, dbus_err,
    input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc
  );
endinterface

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone-classic port between instruction and data buses with
// round-robin tie-break, grant locking until ack/abort, and a timeout watchdog.
module serv_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  serv_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic            last_dbus;
  logic [TO_W-1:0] to_cnt;

  logic            pick_d;
  logic            pick_i;
  logic            use_d;
  logic            owner_cyc;
  logic            to_hit;
  logic [31:0]     ld_adr;
  logic [31:0]     ld_dat;
  logic [3:0]      ld_sel;
  logic            ld_we;

  function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
    return (&v) ? v : v + TO_W'(1);
  endfunction

  // On a tie the requester that did not win last time is granted.
  assign pick_d = bus.dbus_cyc & (~bus.ibus_cyc | ~last_dbus);
  assign pick_i = bus.ibus_cyc & ~pick_d;

  assign use_d     = (state == IDLE) ? pick_d : (state == GNT_D);
  assign owner_cyc = (state == GNT_I) ? bus.ibus_cyc : bus.dbus_cyc;
  assign to_hit    = (TIMEOUT > 0) && (to_cnt == TO_LAST);

  // Port fields always come from exactly one master; ibus is a fixed word read.
  assign ld_adr = use_d ? bus.dbus_adr : bus.ibus_adr;
  assign ld_dat = use_d ? bus.dbus_dat : 32'h0;
  assign ld_sel = use_d ? bus.dbus_sel : 4'hf;
  assign ld_we  = use_d & bus.dbus_we;

  assign bus.ibus_ack = bus.wb_ack & (state == GNT_I);
  assign bus.dbus_ack = bus.wb_ack & (state == GNT_D);
  assign bus.ibus_rdt = bus.wb_rdt;
  assign bus.dbus_rdt = bus.wb_rdt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      last_dbus    <= 1'b0;
      to_cnt       <= '0;
      bus.wb_cyc   <= 1'b0;
      bus.wb_we    <= 1'b0;
      bus.wb_adr   <= 32'h0;
      bus.wb_dat   <= 32'h0;
      bus.wb_sel   <= 4'h0;
      bus.ibus_err <= 1'b0;
      bus.dbus_err <= 1'b0;
    end else begin
      bus.ibus_err <= 1'b0;
      bus.dbus_err <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (pick_d || pick_i) begin
            state      <= pick_d ? GNT_D : GNT_I;
            last_dbus  <= pick_d;
            bus.wb_cyc <= 1'b1;
            bus.wb_adr <= ld_adr;
            bus.wb_dat <= ld_dat;
            bus.wb_sel <= ld_sel;
            bus.wb_we  <= ld_we;
          end
        end
        GNT_I, GNT_D: begin
          // Ack beats expiry; an owner that has walked away gets no error.
          if (bus.wb_ack || !owner_cyc) begin
            state      <= IDLE;
            bus.wb_cyc <= 1'b0;
            to_cnt     <= '0;
          end else if (to_hit) begin
            state        <= IDLE;
            bus.wb_cyc   <= 1'b0;
            to_cnt       <= '0;
            bus.ibus_err <= (state == GNT_I);
            bus.dbus_err <= (state == GNT_D);
          end else begin
            to_cnt     <= to_sat_inc(to_cnt);
            bus.wb_adr <= ld_adr;
            bus.wb_dat <= ld_dat;
            bus.wb_sel <= ld_sel;
            bus.wb_we  <= ld_we;
          end
        end
        default: begin
          state      <= IDLE;
          bus.wb_cyc <= 1'b0;
          to_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed bench for serv_bus_arbiter: arbitration, ack routing, abort,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_serv_bus_arbiter;

  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  serv_bus_arbiter_if bus ();

  serv_bus_arbiter #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ibus_adr = 32'h0;
    bus.ibus_cyc = 1'b0;
    bus.dbus_adr = 32'h0;
    bus.dbus_dat = 32'h0;
    bus.dbus_sel = 4'h0;
    bus.dbus_we  = 1'b0;
    bus.dbus_cyc = 1'b0;
    bus.wb_rdt   = 32'h0;
    bus.wb_ack   = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    #2;
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    #2;
    chk("rst_cyc", bus.wb_cyc, 0);
    chk("rst_adr", bus.wb_adr, 0);
    chk("rst_sel", bus.wb_sel, 0);
    chk("rst_we",  bus.wb_we,  0);
    chk("rst_err", {bus.ibus_err, bus.dbus_err, bus.ibus_ack, bus.dbus_ack}, 0);
    apply_reset();

    // Single ibus fetch, ack on the second granted cycle.
    bus.ibus_cyc = 1'b1;
    bus.ibus_adr = 32'h100;
    settle();
    chk("t1_cyc_c0", bus.wb_cyc, 0);
    tick();
    settle();
    chk("t1_cyc_c1", bus.wb_cyc, 1);
    chk("t1_adr", bus.wb_adr, 32'h100);
    chk("t1_sel", bus.wb_sel, 4'hf);
    chk("t1_we",  bus.wb_we,  0);
    chk("t1_dat", bus.wb_dat, 0);
    chk("t1_noack_c1", bus.ibus_ack, 0);
    tick();
    bus.wb_ack = 1'b1;
    bus.wb_rdt = 32'hDEADBEEF;
    settle();
    chk("t1_iack", bus.ibus_ack, 1);
    chk("t1_irdt", bus.ibus_rdt, 32'hDEADBEEF);
    chk("t1_drdt", bus.dbus_rdt, 32'hDEADBEEF);
    chk("t1_dack", bus.dbus_ack, 0);
    tick();
    bus.wb_ack = 1'b0;
    bus.ibus_cyc = 1'b0;
    settle();
    chk("t1_cyc_after", bus.wb_cyc, 0);
    chk("t1_iack_after", bus.ibus_ack, 0);

    // Tie after reset: dbus first, then ibus after one dead cycle.
    apply_reset();
    bus.ibus_cyc = 1'b1;
    bus.ibus_adr = 32'h300;
    bus.dbus_cyc = 1'b1;
    bus.dbus_adr = 32'h200;
    bus.dbus_we  = 1'b1;
    bus.dbus_sel = 4'h3;
    bus.dbus_dat = 32'h1234;
    tick();
    settle();
    chk("t2_cyc", bus.wb_cyc, 1);
    chk("t2_adr", bus.wb_adr, 32'h200);
    chk("t2_we",  bus.wb_we,  1);
    chk("t2_sel", bus.wb_sel, 4'h3);
    chk("t2_dat", bus.wb_dat, 32'h1234);
    bus.wb_ack = 1'b1;
    settle();
    chk("t2_dack", bus.dbus_ack, 1);
    chk("t2_iack", bus.ibus_ack, 0);
    tick();
    bus.wb_ack = 1'b0;
    bus.dbus_cyc = 1'b0;
    settle();
    chk("t2_dead", bus.wb_cyc, 0);
    tick();
    settle();
    chk("t2_icyc", bus.wb_cyc, 1);
    chk("t2_iadr", bus.wb_adr, 32'h300);
    chk("t2_iwe",  bus.wb_we,  0);
    chk("t2_isel", bus.wb_sel, 4'hf);
    chk("t2_idat", bus.wb_dat, 0);
    bus.wb_ack = 1'b1;
    settle();
    chk("t2_iack2", bus.ibus_ack, 1);
    tick();
    bus.wb_ack = 1'b0;
    bus.ibus_cyc = 1'b0;
    settle();

    // Both held: grants alternate D,I,D,I,... over 8 transfers.
    bus.ibus_cyc = 1'b1;
    bus.ibus_adr = 32'h500;
    bus.dbus_cyc = 1'b1;
    bus.dbus_adr = 32'h400;
    for (int k = 0; k < 8; k++) begin
      logic exp_d;
      exp_d = (k % 2) == 0;
      settle();
      chk("t3_dead", bus.wb_cyc, 0);
      tick();
      settle();
      chk("t3_cyc", bus.wb_cyc, 1);
      chk("t3_adr", bus.wb_adr, exp_d ? 32'h400 : 32'h500);
      bus.wb_ack = 1'b1;
      settle();
      chk("t3_dack", bus.dbus_ack, exp_d);
      chk("t3_iack", bus.ibus_ack, !exp_d);
      tick();
      bus.wb_ack = 1'b0;
    end
    bus.ibus_cyc = 1'b0;
    bus.dbus_cyc = 1'b0;
    tick();

    // Timeout: dbus granted, no ack; error four cycles after cyc rises.
    bus.dbus_cyc = 1'b1;
    bus.dbus_we  = 1'b0;
    tick();
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("t4_cyc_g", bus.wb_cyc, 1);
      chk("t4_noerr_g", bus.dbus_err, 0);
      tick();
    end
    settle();
    chk("t4_err", bus.dbus_err, 1);
    chk("t4_ierr", bus.ibus_err, 0);
    chk("t4_cyc_off", bus.wb_cyc, 0);
    chk("t4_dack_off", bus.dbus_ack, 0);
    bus.dbus_cyc = 1'b0;
    tick();
    settle();
    chk("t4_err_pulse", bus.dbus_err, 0);

    // Ack on the expiry cycle wins over the error.
    bus.dbus_cyc = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) tick();
    bus.wb_ack = 1'b1;
    settle();
    chk("t4b_cyc", bus.wb_cyc, 1);
    chk("t4b_ack", bus.dbus_ack, 1);
    tick();
    bus.wb_ack = 1'b0;
    bus.dbus_cyc = 1'b0;
    settle();
    chk("t4b_noerr", bus.dbus_err, 0);
    chk("t4b_cyc_off", bus.wb_cyc, 0);
    tick();
    settle();
    chk("t4b_noerr2", bus.dbus_err, 0);

    // Abort: ibus drops cyc, then a stray ack arrives in IDLE.
    bus.ibus_cyc = 1'b1;
    bus.ibus_adr = 32'h600;
    tick();
    settle();
    chk("t5_cyc", bus.wb_cyc, 1);
    bus.ibus_cyc = 1'b0;
    settle();
    chk("t5_noack", bus.ibus_ack, 0);
    tick();
    settle();
    chk("t5_idle", bus.wb_cyc, 0);
    bus.wb_ack = 1'b1;
    settle();
    chk("t5_stray", {bus.ibus_ack, bus.dbus_ack}, 0);
    tick();
    bus.wb_ack = 1'b0;
    settle();
    chk("t5_still_idle", bus.wb_cyc, 0);
    chk("t5_noerr", {bus.ibus_err, bus.dbus_err}, 0);

    // Asynchronous reset mid-dbus transfer.
    bus.dbus_cyc = 1'b1;
    bus.dbus_adr = 32'h700;
    bus.dbus_we  = 1'b1;
    tick();
    bus.wb_ack = 1'b1;
    settle();
    chk("t6_pre_ack", bus.dbus_ack, 1);
    settle();
    i_rst_n = 1'b0;
    settle();
    chk("t6_cyc", bus.wb_cyc, 0);
    chk("t6_acks", {bus.ibus_ack, bus.dbus_ack}, 0);
    chk("t6_adr", bus.wb_adr, 0);
    chk("t6_we", bus.wb_we, 0);
    bus.wb_ack = 1'b0;
    bus.dbus_cyc = 1'b0;
    tick();
    #2;
    i_rst_n = 1'b1;
    tick();
    bus.ibus_cyc = 1'b1;
    bus.ibus_adr = 32'h800;
    bus.dbus_cyc = 1'b1;
    bus.dbus_adr = 32'h900;
    tick();
    settle();
    chk("t6_tie_adr", bus.wb_adr, 32'h900);
    chk("t6_tie_we", bus.wb_we, 1);
    bus.wb_ack = 1'b1;
    settle();
    chk("t6_tie_ack", bus.dbus_ack, 1);
    tick();
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
